// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues instruction-SRAM requests and
// buffers branch/exception redirects until a fetch actually fires.
module pre_if_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h1C00_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W:0]   id_to_preif_ibus,
    input  logic            excep_flush_i,
    input  logic [PC_W-1:0] excep_entry_i,
    input  logic            if_allowin_i,
    output logic            inst_sram_req_o,
    output logic [PC_W-1:0] inst_sram_addr_o,
    input  logic            inst_sram_addr_ok_i,
    output logic            preif_to_if_valid_o,
    output logic [PC_W-1:0] preif_pc_o,
    output logic            preif_adef_o
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic            br_pend_r;
    logic [PC_W-1:0] br_addr_r;
    logic            ex_pend_r;
    logic [PC_W-1:0] ex_addr_r;

    logic            jmp_flag;
    logic [PC_W-1:0] jmp_addr;
    logic [PC_W-1:0] next_pc;
    logic            run;
    logic            adef;
    logic            fire;

    assign jmp_flag = id_to_preif_ibus[PC_W];
    assign jmp_addr = id_to_preif_ibus[PC_W-1:0];
    assign run      = (state_r == RUN);

    // Exceptions outrank branches; live redirects outrank buffered ones.
    always_comb begin
        next_pc = pc_r + PC_W'(4);
        if (excep_flush_i)  next_pc = excep_entry_i;
        else if (ex_pend_r) next_pc = ex_addr_r;
        else if (jmp_flag)  next_pc = jmp_addr;
        else if (br_pend_r) next_pc = br_addr_r;
    end

    assign adef = |next_pc[1:0];
    // A misaligned PC fires straight to IF without an SRAM request.
    assign fire = run & if_allowin_i & (adef | inst_sram_addr_ok_i);

    assign inst_sram_req_o     = run & if_allowin_i & ~adef;
    assign inst_sram_addr_o    = run ? next_pc : '0;
    assign preif_to_if_valid_o = fire;
    assign preif_pc_o          = run ? next_pc : '0;
    assign preif_adef_o        = fire & adef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= BOOT;
            pc_r      <= RESET_PC - PC_W'(4);
            br_pend_r <= 1'b0;
            br_addr_r <= '0;
            ex_pend_r <= 1'b0;
            ex_addr_r <= '0;
        end else begin
            case (state_r)
                BOOT: state_r <= RUN;
                RUN: begin
                    if (fire) begin
                        pc_r      <= next_pc;
                        br_pend_r <= 1'b0;
                        ex_pend_r <= 1'b0;
                    end else if (excep_flush_i) begin
                        ex_pend_r <= 1'b1;
                        ex_addr_r <= excep_entry_i;
                        br_pend_r <= 1'b0;
                    end else if (jmp_flag && !ex_pend_r) begin
                        br_pend_r <= 1'b1;
                        br_addr_r <= jmp_addr;
                    end
                end
                default: state_r <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed table-driven bench for pre_if_stage, plus hand-written reset sequences.
module tb_pre_if_stage;

    logic        clk;
    logic        rst_n;
    logic [32:0] id_to_preif_ibus;
    logic        excep_flush_i;
    logic [31:0] excep_entry_i;
    logic        if_allowin_i;
    logic        inst_sram_req_o;
    logic [31:0] inst_sram_addr_o;
    logic        inst_sram_addr_ok_i;
    logic        preif_to_if_valid_o;
    logic [31:0] preif_pc_o;
    logic        preif_adef_o;

    int n_cmp;
    int n_err;

    pre_if_stage #(.PC_W(32), .RESET_PC(32'h1C00_0000)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .id_to_preif_ibus    (id_to_preif_ibus),
        .excep_flush_i       (excep_flush_i),
        .excep_entry_i       (excep_entry_i),
        .if_allowin_i        (if_allowin_i),
        .inst_sram_req_o     (inst_sram_req_o),
        .inst_sram_addr_o    (inst_sram_addr_o),
        .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
        .preif_to_if_valid_o (preif_to_if_valid_o),
        .preif_pc_o          (preif_pc_o),
        .preif_adef_o        (preif_adef_o)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        jmp;
        logic [31:0] jaddr;
        logic        flush;
        logic [31:0] entry;
        logic        allow;
        logic        ok;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        adef;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(logic jmp, logic [31:0] jaddr, logic flush, logic [31:0] entry,
                                logic allow, logic ok, logic req, logic [31:0] addr,
                                logic valid, logic adef);
        vec_t v;
        v.jmp = jmp; v.jaddr = jaddr; v.flush = flush; v.entry = entry;
        v.allow = allow; v.ok = ok; v.req = req; v.addr = addr;
        v.valid = valid; v.adef = adef;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string name, logic req, logic [31:0] addr, logic valid,
                              logic [31:0] pc, logic adef);
        check({name, ".req"},   32'(inst_sram_req_o),     32'(req));
        check({name, ".addr"},  inst_sram_addr_o,         addr);
        check({name, ".valid"}, 32'(preif_to_if_valid_o), 32'(valid));
        check({name, ".pc"},    preif_pc_o,               pc);
        check({name, ".adef"},  32'(preif_adef_o),        32'(adef));
    endtask

    // driver task: inputs change #1 after the rising edge
    task automatic drive(logic jmp, logic [31:0] jaddr, logic flush, logic [31:0] entry,
                         logic allow, logic ok);
        @(posedge clk);
        #1;
        id_to_preif_ibus    = {jmp, jaddr};
        excep_flush_i       = flush;
        excep_entry_i       = entry;
        if_allowin_i        = allow;
        inst_sram_addr_ok_i = ok;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        id_to_preif_ibus    = '0;
        excep_flush_i       = 1'b0;
        excep_entry_i       = '0;
        if_allowin_i        = 1'b1;
        inst_sram_addr_ok_i = 1'b1;

        //            jmp jaddr          fl entry          al ok  req addr           v  adef
        vecs[0]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0000, 1, 0);
        vecs[1]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0004, 1, 0);
        vecs[2]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0008, 1, 0);
        vecs[3]  = mk(1, 32'h1C00_0100,  0, 32'h0,         1, 1,  1, 32'h1C00_0100, 1, 0);
        vecs[4]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0104, 1, 0);
        vecs[5]  = mk(1, 32'h1C00_0200,  0, 32'h0,         1, 0,  1, 32'h1C00_0200, 0, 0);
        vecs[6]  = mk(0, 32'h0,          0, 32'h0,         1, 0,  1, 32'h1C00_0200, 0, 0);
        vecs[7]  = mk(0, 32'h0,          0, 32'h0,         1, 0,  1, 32'h1C00_0200, 0, 0);
        vecs[8]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0200, 1, 0);
        vecs[9]  = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0204, 1, 0);
        vecs[10] = mk(1, 32'h1C00_0300,  1, 32'h1C00_8000, 1, 0,  1, 32'h1C00_8000, 0, 0);
        vecs[11] = mk(1, 32'h1C00_0300,  0, 32'h0,         1, 0,  1, 32'h1C00_8000, 0, 0);
        vecs[12] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_8000, 1, 0);
        vecs[13] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_8004, 1, 0);
        vecs[14] = mk(1, 32'h1C00_0400,  0, 32'h0,         0, 1,  0, 32'h1C00_0400, 0, 0);
        vecs[15] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0400, 1, 0);
        vecs[16] = mk(1, 32'h1C00_0102,  0, 32'h0,         1, 1,  0, 32'h1C00_0102, 1, 1);
        vecs[17] = mk(0, 32'h0,          0, 32'h0,         1, 0,  0, 32'h1C00_0106, 1, 1);
        vecs[18] = mk(1, 32'h1C00_1000,  0, 32'h0,         1, 1,  1, 32'h1C00_1000, 1, 0);
        vecs[19] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_1004, 1, 0);
        vecs[20] = mk(1, 32'h1C00_0500,  1, 32'h1C00_8000, 1, 1,  1, 32'h1C00_8000, 1, 0);
        vecs[21] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_8004, 1, 0);
        vecs[22] = mk(1, 32'h1C00_0500,  0, 32'h0,         1, 0,  1, 32'h1C00_0500, 0, 0);
        vecs[23] = mk(1, 32'h1C00_0600,  0, 32'h0,         1, 0,  1, 32'h1C00_0600, 0, 0);
        vecs[24] = mk(0, 32'h0,          0, 32'h0,         1, 0,  1, 32'h1C00_0600, 0, 0);
        vecs[25] = mk(0, 32'h0,          0, 32'h0,         1, 1,  1, 32'h1C00_0600, 1, 0);

        // outputs held low during reset and in the boot cycle
        repeat (2) @(negedge clk);
        check_outs("in_reset", 0, 32'h0, 0, 32'h0, 0);
        rst_n = 1'b1;
        #1;
        check_outs("boot", 0, 32'h0, 0, 32'h0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].jmp, vecs[i].jaddr, vecs[i].flush, vecs[i].entry,
                  vecs[i].allow, vecs[i].ok);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                       vecs[i].addr, vecs[i].adef);
        end

        // async reset with a pending branch
        drive(1, 32'h1C00_0700, 0, 32'h0, 1, 0);
        @(negedge clk);
        check_outs("pend_set", 1, 32'h1C00_0700, 0, 32'h1C00_0700, 0);
        drive(0, 32'h0, 0, 32'h0, 1, 0);
        @(negedge clk);
        check_outs("pend_hold", 1, 32'h1C00_0700, 0, 32'h1C00_0700, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 32'h0, 0, 32'h0, 0);
        inst_sram_addr_ok_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reboot", 0, 32'h0, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 32'h0, 1, 1);
        @(negedge clk);
        check_outs("restart0", 1, 32'h1C00_0000, 1, 32'h1C00_0000, 0);
        drive(0, 32'h0, 0, 32'h0, 1, 1);
        @(negedge clk);
        check_outs("restart1", 1, 32'h1C00_0004, 1, 32'h1C00_0004, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
